// File: rtl/stream_coprocessor.sv
// -----------------------------------------------------------------------------
// stream_coprocessor
//
// Streaming coprocessor that sits between the UART byte-framer and the
// response serialiser. Each accepted input beat produces one result on the
// next rising edge. The operation applied to the beat is chosen by
// control[1:0], which is sampled together with the beat:
//   00 PASS : result = zero-extended beat
//   01 TAP  : result = hist[k] (k = control[5:2]), or 0 when k >= DEPTH
//   10 PAIR : result = hist[0] + beat
//   11 ACC  : result = acc + beat; acc takes the result
// Any accepted beat that is not in ACC mode clears the accumulator.
// Every accepted beat, in every mode, is shifted into the history.
//
// Optional feature macro: STREAM_COPROC_SAT_EN
//   When defined, PAIR/ACC results clamp to all-ones on carry-out instead of
//   wrapping. The sticky overflow flag is set on carry-out in both builds.
//
// Ports
//   clk         in   1           clock, rising edge
//   rst         in   1           asynchronous active-high reset
//   din         in   WIDTH_DIN   input beat
//   din_valid   in   1           input beat present
//   din_ready   out  1           block can accept a beat this cycle
//   control     in   6           [1:0] mode, [5:2] tap index
//   dout        out  WIDTH_DOUT  result register
//   dout_valid  out  1           dout holds an unconsumed result
//   dout_ready  in   1           downstream consumes the result
//   overflow    out  1           sticky carry-out flag
// -----------------------------------------------------------------------------
module stream_coprocessor #(
    parameter int WIDTH_DIN  = 128,
    parameter int WIDTH_DOUT = 128,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_DIN-1:0]  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [5:0]            control,
    output logic [WIDTH_DOUT-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overflow
);

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_TAP  = 2'b01;
    localparam logic [1:0] MODE_ACC  = 2'b11;

    logic [WIDTH_DIN-1:0]  hist_q [DEPTH];
    logic [WIDTH_DOUT-1:0] acc_q, acc_d;
    logic [WIDTH_DOUT-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  overflow_q, overflow_d;

    logic                  accept;
    logic [1:0]            mode;
    logic [3:0]            tap_k;
    logic [WIDTH_DOUT-1:0] x;
    logic [WIDTH_DOUT-1:0] hist0_x;
    logic [WIDTH_DOUT-1:0] tap_val;
    logic [WIDTH_DOUT-1:0] add_a;
    logic [WIDTH_DOUT:0]   sum;
    logic                  carry;
    logic [WIDTH_DOUT-1:0] result;

    // Single output slot: a new beat fits whenever the slot is empty or
    // is being drained this very cycle.
    assign din_ready = !dout_valid_q | dout_ready;
    assign accept    = din_valid & din_ready;
    assign mode      = control[1:0];
    assign tap_k     = control[5:2];

    always_comb begin
        x = '0;
        x[WIDTH_DIN-1:0] = din;

        hist0_x = '0;
        hist0_x[WIDTH_DIN-1:0] = hist_q[0];

        // Tap indices at or beyond DEPTH fall through the loop and read 0.
        tap_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(tap_k) == i) begin
                tap_val[WIDTH_DIN-1:0] = hist_q[i];
            end
        end

        // PAIR and ACC share one adder; only the left operand differs.
        add_a = (mode == MODE_ACC) ? acc_q : hist0_x;
        sum   = {1'b0, add_a} + {1'b0, x};
        carry = sum[WIDTH_DOUT];

        case (mode)
            MODE_PASS: result = x;
            MODE_TAP:  result = tap_val;
            default: begin
                result = sum[WIDTH_DOUT-1:0];
`ifdef STREAM_COPROC_SAT_EN
                if (carry) begin
                    result = '1;
                end
`endif
            end
        endcase
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        acc_d        = acc_q;
        overflow_d   = overflow_q;

        if (accept) begin
            dout_d       = result;
            dout_valid_d = 1'b1;
            // A saturated result lands in acc, so acc stays pinned at
            // all-ones until a non-ACC beat clears it.
            acc_d        = (mode == MODE_ACC) ? result : '0;
            if (mode[1] && carry) begin
                overflow_d = 1'b1;
            end
        end else if (dout_ready) begin
            // Consumed with nothing new: dout keeps its last value.
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            if (accept) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    hist_q[i] <= hist_q[i-1];
                end
                hist_q[0] <= din;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;

endmodule
